sumador_param: RTL and testbench

- Parametrised successor to the team's 4-bit registered adder/counter.
- WIDTH-bit datapath with four operating modes: registered add, accumulate, up-count and down-count.
- Carry in/out ports (RCI/RCO) allow several instances to be chained into wider adders or counters.
- Adds an optional saturation mode, a sticky overflow flag and a synchronous clear. Sits in the arithmetic datapath and is driven by a probador-style stimulus block.

---
 rtl/sumador_param.sv | 86 ++++++++
 tb/tb_sumador_param.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sumador_param.sv
// Registered WIDTH-bit add/accumulate/up-count/down-count unit with chainable carry, optional saturation and sticky overflow.
// One-cycle latency from sampled inputs to Q/RCO/OVF; no backpressure, a new operation can be issued every cycle.
module sumador_param #(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             ENB,
    input  logic             CLR,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             RCI,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             OVF
);

    typedef enum logic [1:0] {
        SUMA      = 2'b00,
        ACUM      = 2'b01,
        CUENTA_UP = 2'b10,
        CUENTA_DN = 2'b11
    } modo_e;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q, q_d;
    logic             rco_q, rco_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;

    // ACUM feeds the current result back in place of B.
    assign addend = (modo_e'(MODO) == ACUM) ? q_q : B;
    assign sum    = {1'b0, A} + {1'b0, addend} + {{WIDTH{1'b0}}, RCI};

    always_comb begin
        q_d   = q_q;
        rco_d = 1'b0;
        ovf_d = ovf_q;
        if (CLR) begin
            q_d   = '0;
            ovf_d = 1'b0;
        end else if (ENB) begin
            case (modo_e'(MODO))
                SUMA, ACUM: begin
                    rco_d = sum[WIDTH];
                    q_d   = (SAT && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
                end
                CUENTA_UP: begin
                    if (RCI) begin
                        rco_d = (q_q == '1);
                        q_d   = q_q + ONE;
                    end
                end
                CUENTA_DN: begin
                    if (RCI) begin
                        rco_d = (q_q == '0);
                        q_d   = q_q - ONE;
                    end
                end
                default: ;
            endcase
            ovf_d = ovf_q | rco_d;
        end
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            q_q   <= '0;
            rco_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            rco_q <= rco_d;
            ovf_q <= ovf_d;
        end
    end

    assign Q   = q_q;
    assign RCO = rco_q;
    assign OVF = ovf_q;

endmodule

// File: tb/tb_sumador_param.sv
// Bench for sumador_param: directed vector table, reset corner cases, randomized run against an arithmetic model, and a two-stage 4-bit chain.
// Drives inputs #1 after a rising edge and samples outputs #1 after the following rising edge.
module tb_sumador_param;

    logic       CLK;
    logic       RESET_L;
    logic       ENB, CLR, RCI;
    logic [1:0] MODO;
    logic [7:0] A, B;
    logic [7:0] q0, q1;
    logic       rco0, rco1, ovf0, ovf1;

    logic       ch_enb, ch_clr;
    logic [3:0] ch_zero;
    logic [3:0] lo_q, hi_q;
    logic       lo_rco, lo_ovf, hi_rco, hi_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    int mq[2];
    bit mrco[2];
    bit movf[2];

    typedef struct {
        bit         clr;
        bit         enb;
        logic [1:0] modo;
        logic [7:0] a;
        logic [7:0] b;
        bit         rci;
        logic [7:0] q0;
        logic [7:0] q1;
        bit         rco;
        bit         ovf;
    } vec_t;

    vec_t vecs[18];

    sumador_param #(.WIDTH(8), .SAT(1'b0)) dut_wrap (
        .CLK(CLK), .RESET_L(RESET_L), .ENB(ENB), .CLR(CLR), .MODO(MODO),
        .A(A), .B(B), .RCI(RCI), .Q(q0), .RCO(rco0), .OVF(ovf0)
    );

    sumador_param #(.WIDTH(8), .SAT(1'b1)) dut_sat (
        .CLK(CLK), .RESET_L(RESET_L), .ENB(ENB), .CLR(CLR), .MODO(MODO),
        .A(A), .B(B), .RCI(RCI), .Q(q1), .RCO(rco1), .OVF(ovf1)
    );

    sumador_param #(.WIDTH(4), .SAT(1'b0)) dut_lo (
        .CLK(CLK), .RESET_L(RESET_L), .ENB(ch_enb), .CLR(ch_clr), .MODO(2'b10),
        .A(ch_zero), .B(ch_zero), .RCI(1'b1), .Q(lo_q), .RCO(lo_rco), .OVF(lo_ovf)
    );

    sumador_param #(.WIDTH(4), .SAT(1'b0)) dut_hi (
        .CLK(CLK), .RESET_L(RESET_L), .ENB(ch_enb), .CLR(ch_clr), .MODO(2'b10),
        .A(ch_zero), .B(ch_zero), .RCI(lo_rco), .Q(hi_q), .RCO(hi_rco), .OVF(hi_ovf)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i] = 0; mrco[i] = 1'b0; movf[i] = 1'b0;
        end
    endtask

    // Reference behaviour in plain integer arithmetic; index 0 wraps, index 1 saturates.
    task automatic model_step();
        int s;
        for (int i = 0; i < 2; i++) begin
            if (CLR) begin
                mq[i] = 0; mrco[i] = 1'b0; movf[i] = 1'b0;
            end else if (!ENB) begin
                mrco[i] = 1'b0;
            end else begin
                case (MODO)
                    2'b00, 2'b01: begin
                        s = int'(A) + int'(RCI) + ((MODO == 2'b01) ? mq[i] : int'(B));
                        mrco[i] = (s > 255);
                        mq[i] = (i == 1 && s > 255) ? 255 : s % 256;
                    end
                    2'b10: begin
                        mrco[i] = RCI && (mq[i] == 255);
                        if (RCI) mq[i] = (mq[i] + 1) % 256;
                    end
                    default: begin
                        mrco[i] = RCI && (mq[i] == 0);
                        if (RCI) mq[i] = (mq[i] + 255) % 256;
                    end
                endcase
                if (mrco[i]) movf[i] = 1'b1;
            end
        end
    endtask

    task automatic tick(input bit clr, input bit enb, input logic [1:0] modo,
                        input logic [7:0] a, input logic [7:0] b, input bit rci);
        CLR = clr; ENB = enb; MODO = modo; A = a; B = b; RCI = rci;
        @(posedge CLK);
        #1;
        model_step();
    endtask

    task automatic check_model(input string tag);
        check({tag, "_q_wrap"},   int'(q0),   mq[0]);
        check({tag, "_rco_wrap"}, int'(rco0), int'(mrco[0]));
        check({tag, "_ovf_wrap"}, int'(ovf0), int'(movf[0]));
        check({tag, "_q_sat"},    int'(q1),   mq[1]);
        check({tag, "_rco_sat"},  int'(rco1), int'(mrco[1]));
        check({tag, "_ovf_sat"},  int'(ovf1), int'(movf[1]));
    endtask

    initial begin
        vecs[0]  = '{0, 1, 2'b00, 8'hF0, 8'h20, 1, 8'h11, 8'hFF, 1, 1};
        vecs[1]  = '{0, 1, 2'b00, 8'h01, 8'h01, 0, 8'h02, 8'h02, 0, 1};
        vecs[2]  = '{0, 0, 2'b00, 8'h01, 8'h01, 0, 8'h02, 8'h02, 0, 1};
        vecs[3]  = '{1, 1, 2'b00, 8'h01, 8'h01, 1, 8'h00, 8'h00, 0, 0};
        vecs[4]  = '{0, 1, 2'b00, 8'hFE, 8'h00, 0, 8'hFE, 8'hFE, 0, 0};
        vecs[5]  = '{0, 1, 2'b01, 8'h05, 8'hAA, 0, 8'h03, 8'hFF, 1, 1};
        vecs[6]  = '{0, 1, 2'b01, 8'h00, 8'h00, 0, 8'h03, 8'hFF, 0, 1};
        vecs[7]  = '{0, 1, 2'b00, 8'hFD, 8'h00, 0, 8'hFD, 8'hFD, 0, 1};
        vecs[8]  = '{0, 1, 2'b10, 8'h00, 8'h00, 1, 8'hFE, 8'hFE, 0, 1};
        vecs[9]  = '{0, 1, 2'b10, 8'h00, 8'h00, 1, 8'hFF, 8'hFF, 0, 1};
        vecs[10] = '{0, 1, 2'b10, 8'h00, 8'h00, 1, 8'h00, 8'h00, 1, 1};
        vecs[11] = '{0, 1, 2'b10, 8'h00, 8'h00, 1, 8'h01, 8'h01, 0, 1};
        vecs[12] = '{0, 1, 2'b10, 8'h00, 8'h00, 0, 8'h01, 8'h01, 0, 1};
        vecs[13] = '{0, 0, 2'b10, 8'h00, 8'h00, 1, 8'h01, 8'h01, 0, 1};
        vecs[14] = '{0, 1, 2'b11, 8'h00, 8'h00, 1, 8'h00, 8'h00, 0, 1};
        vecs[15] = '{0, 1, 2'b11, 8'h00, 8'h00, 1, 8'hFF, 8'hFF, 1, 1};
        vecs[16] = '{0, 1, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1};
        vecs[17] = '{1, 1, 2'b11, 8'h00, 8'h00, 1, 8'h00, 8'h00, 0, 0};

        RESET_L = 1'b0;
        ENB = 1'b0; CLR = 1'b0; MODO = 2'b00; A = '0; B = '0; RCI = 1'b0;
        ch_enb = 1'b0; ch_clr = 1'b0; ch_zero = '0;
        model_reset();

        #2;
        check("reset_q", int'(q0), 0);
        check("reset_rco_ovf", int'({rco0, ovf0, rco1, ovf1}), 0);
        @(posedge CLK);
        #1;
        check("reset_hold_q", int'({q0, q1}), 0);
        #2 RESET_L = 1'b1;

        for (int i = 0; i < 18; i++) begin
            tick(vecs[i].clr, vecs[i].enb, vecs[i].modo, vecs[i].a, vecs[i].b, vecs[i].rci);
            check($sformatf("vec%0d_q_wrap", i), int'(q0), int'(vecs[i].q0));
            check($sformatf("vec%0d_q_sat", i),  int'(q1), int'(vecs[i].q1));
            check($sformatf("vec%0d_rco", i),    int'(rco0), int'(vecs[i].rco));
            check($sformatf("vec%0d_ovf", i),    int'(ovf0), int'(vecs[i].ovf));
            check($sformatf("vec%0d_sat_flags", i), int'({rco1, ovf1}), int'({vecs[i].rco, vecs[i].ovf}));
        end

        // Asynchronous reset while counting, with RCO and OVF set.
        tick(0, 1, 2'b00, 8'hFF, 8'h00, 0);
        tick(0, 1, 2'b10, 8'h00, 8'h00, 1);
        check("pre_reset_rco", int'(rco0), 1);
        check("pre_reset_q", int'(q0), 0);
        #2 RESET_L = 1'b0;
        #1;
        model_reset();
        check("async_reset_q", int'({q0, q1}), 0);
        check("async_reset_flags", int'({rco0, ovf0, rco1, ovf1}), 0);
        #2 RESET_L = 1'b1;
        tick(0, 1, 2'b10, 8'h00, 8'h00, 1);
        check("resume_q", int'(q0), 1);
        check_model("resume");

        for (int i = 0; i < 300; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ra = 8'hFF;
            tick($urandom_range(0, 19) == 0, $urandom_range(0, 7) != 0,
                 2'($urandom_range(0, 3)), ra, rb, 1'($urandom));
            check_model($sformatf("rnd%0d", i));
        end

        // Registered chain: the upper stage advances one edge after the lower RCO pulse.
        ENB = 1'b0; CLR = 1'b0;
        ch_clr = 1'b1;
        @(posedge CLK);
        #1;
        ch_clr = 1'b0;
        ch_enb = 1'b1;
        check("chain_clr", int'({hi_q, lo_q}), 0);
        for (int n = 1; n <= 40; n++) begin
            int exp_lo, exp_hi;
            @(posedge CLK);
            #1;
            exp_lo = n % 16;
            exp_hi = ((n - 1) / 16) % 16;
            check($sformatf("chain%0d_q", n), int'({hi_q, lo_q}), exp_hi * 16 + exp_lo);
            check($sformatf("chain%0d_lo_rco", n), int'(lo_rco), int'(exp_lo == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
